// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store width and alignment unit:
// funct3 encodings, FSM state encoding and the access-size decoder.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic       legal;
        logic [3:0] bytes;
        logic       is_signed;
    } size_info_t;

    // Decode funct3 into access size and signedness. Stores only have the
    // signed encodings; D and WU exist only on a 64-bit datapath.
    function automatic size_info_t size_decode(input logic [2:0] funct3,
                                               input logic       we,
                                               input int         xlen);
        size_info_t info;
        info = '{legal: 1'b0, bytes: 4'd0, is_signed: 1'b0};
        case (funct3)
            F3_B:  info = '{legal: 1'b1, bytes: 4'd1, is_signed: 1'b1};
            F3_H:  info = '{legal: 1'b1, bytes: 4'd2, is_signed: 1'b1};
            F3_W:  info = '{legal: 1'b1, bytes: 4'd4, is_signed: 1'b1};
            F3_D:  if (xlen == 64) info = '{legal: 1'b1, bytes: 4'd8, is_signed: 1'b1};
            F3_BU: if (!we) info = '{legal: 1'b1, bytes: 4'd1, is_signed: 1'b0};
            F3_HU: if (!we) info = '{legal: 1'b1, bytes: 4'd2, is_signed: 1'b0};
            F3_WU: if (!we && xlen == 64) info = '{legal: 1'b1, bytes: 4'd4, is_signed: 1'b0};
            default: ;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load extension: keeps the low i_bytes bytes of an LSB-justified word and
// fills the upper bytes with the loaded sign bit or with zeros.
module lsu_extend #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_data,
    input  logic [3:0]      i_bytes,
    input  logic            i_is_signed,
    output logic [XLEN-1:0] o_data
);
    localparam int NB = XLEN / 8;

    logic w_sign;

    // Sign bit is the MSB of the highest byte actually loaded
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path can leave it unassigned and infer a latch.
        w_sign = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (int'(i_bytes) == i + 1) w_sign = i_data[8*i+7];
        end
    end

    // Pass loaded bytes through, replicate the fill byte above them
    always_comb begin
        o_data = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(i_bytes)) o_data[8*i +: 8] = i_data[8*i +: 8];
            else                   o_data[8*i +: 8] = {8{i_is_signed & w_sign}};
        end
    end

endmodule

// File: rtl/lsu_width_align.sv
// MEM-stage load/store width and alignment unit. Generates lane byte-enables
// and shifted store data, splits word-crossing accesses into two memory
// beats, and assembles/extends load data into a one-cycle response.
module lsu_width_align
    import lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int NB    = XLEN / 8;
    localparam int OFS_W = $clog2(NB);

    state_e             r_state;
    logic               r_we;
    logic               r_signed;
    logic               r_cross;
    logic [OFS_W-1:0]   r_ofs;
    logic [3:0]         r_bytes;
    logic [ADDR_W-1:0]  r_addr1;
    logic [NB-1:0]      r_be1;
    logic [XLEN-1:0]    r_wd1;
    logic [XLEN-1:0]    r_beat0;

    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [NB-1:0]      r_mem_be;
    logic [XLEN-1:0]    r_mem_wdata;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic [XLEN-1:0]    r_rsp_rdata;

    size_info_t         w_info;
    logic [OFS_W-1:0]   w_ofs;
    logic [ADDR_W-1:0]  w_base;
    logic [4:0]         w_span;
    logic               w_cross;
    logic               w_reject;
    logic [2*NB-1:0]    w_mask;
    logic [2*NB-1:0]    w_be_pair;
    logic [2*XLEN-1:0]  w_wd_pair;
    logic [2*XLEN-1:0]  w_rd_pair;
    logic [XLEN-1:0]    w_rd_aligned;
    logic [XLEN-1:0]    w_rd_ext;
    logic               w_last_ack;

    // Request decode: size, lane offset, base address and word crossing
    assign w_info   = size_decode(req_funct3, req_we, XLEN);
    assign w_ofs    = req_addr[OFS_W-1:0];
    assign w_base   = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    assign w_span   = 5'(w_ofs) + 5'(w_info.bytes);
    assign w_cross  = w_span > 5'(NB);
    assign w_reject = !w_info.legal || (w_cross && !ALLOW_MISALIGNED);

    // Size mask of the access, one bit per byte
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(w_info.bytes)) w_mask[i] = 1'b1;
        end
    end

    // Byte enables and store data laid across two consecutive lane words:
    // the low half feeds beat 0, the high half spills into beat 1.
    assign w_be_pair = w_mask << w_ofs;
    assign w_wd_pair = {{XLEN{1'b0}}, req_wdata} << {w_ofs, 3'b000};

    // Load merge: beat 1 bytes sit above beat 0 bytes, then shift down by ofs
    assign w_rd_pair    = (r_state == ST_BEAT1) ? {mem_rdata, r_beat0}
                                                : {{XLEN{1'b0}}, mem_rdata};
    assign w_rd_aligned = XLEN'(w_rd_pair >> {r_ofs, 3'b000});

    lsu_extend #(.XLEN(XLEN)) u_extend (
        .i_data      (w_rd_aligned),
        .i_bytes     (r_bytes),
        .i_is_signed (r_signed),
        .o_data      (w_rd_ext)
    );

    assign w_last_ack = mem_ack && ((r_state == ST_BEAT0 && !r_cross) || r_state == ST_BEAT1);

    // Transaction FSM with registered memory-port and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_signed    <= 1'b0;
            r_cross     <= 1'b0;
            r_ofs       <= '0;
            r_bytes     <= '0;
            r_addr1     <= '0;
            r_be1       <= '0;
            r_wd1       <= '0;
            r_beat0     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_we     <= req_we;
                        r_signed <= w_info.is_signed;
                        r_cross  <= w_cross;
                        r_ofs    <= w_ofs;
                        r_bytes  <= w_info.bytes;
                        r_addr1  <= w_base + ADDR_W'(NB);
                        r_be1    <= w_be_pair[2*NB-1:NB];
                        r_wd1    <= w_wd_pair[2*XLEN-1:XLEN];
                        if (w_reject) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state     <= ST_BEAT0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= req_we;
                            r_mem_addr  <= w_base;
                            r_mem_be    <= w_be_pair[NB-1:0];
                            r_mem_wdata <= w_wd_pair[XLEN-1:0];
                        end
                    end
                end
                ST_BEAT0, ST_BEAT1: begin
                    if (w_last_ack) begin
                        r_state     <= ST_RESP;
                        r_mem_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_we ? '0 : w_rd_ext;
                    end else if (mem_ack) begin
                        // First half of a crossing access: keep its data, move to the next word
                        r_state     <= ST_BEAT1;
                        r_beat0     <= mem_rdata;
                        r_mem_addr  <= r_addr1;
                        r_mem_be    <= r_be1;
                        r_mem_wdata <= r_wd1;
                    end
                end
                ST_RESP: begin
                    r_state   <= ST_IDLE;
                    r_rsp_err <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE) && rst_n;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_width_align.sv
// Self-checking bench for lsu_width_align (XLEN=32): byte-level memory
// responder with programmable ack delay, byte-addressed reference model.
module tb_lsu_width_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        na_req_valid, na_req_ready, na_rsp_valid, na_rsp_err;
    logic [31:0] na_rsp_rdata, na_mem_addr, na_mem_wdata, na_mem_rdata;
    logic        na_mem_req, na_mem_we, na_mem_ack;
    logic [3:0]  na_mem_be;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_delay = 0;
    int stab_viol = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    beat_t       beats[$];
    logic [7:0]  mem_bytes [logic [31:0]];

    always #5 clk = ~clk;

    lsu_width_align #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    lsu_width_align #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_na (
        .clk(clk), .rst_n(rst_n),
        .req_valid(na_req_valid), .req_ready(na_req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(na_rsp_valid), .rsp_rdata(na_rsp_rdata), .rsp_err(na_rsp_err),
        .mem_req(na_mem_req), .mem_we(na_mem_we), .mem_addr(na_mem_addr), .mem_be(na_mem_be),
        .mem_wdata(na_mem_wdata), .mem_ack(na_mem_ack), .mem_rdata(na_mem_rdata)
    );

    assign na_mem_ack   = na_mem_req;
    assign na_mem_rdata = 32'hCAFE_F00D;

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem_bytes.exists(a)) return mem_bytes[a];
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic void ref_decode(input logic we, input logic [2:0] f3,
                                       output bit legal, output int sz, output bit sgn);
        legal = 1'b0; sz = 0; sgn = 1'b0;
        case (f3)
            3'b000: begin legal = 1'b1; sz = 1; sgn = 1'b1; end
            3'b001: begin legal = 1'b1; sz = 2; sgn = 1'b1; end
            3'b010: begin legal = 1'b1; sz = 4; sgn = 1'b1; end
            3'b100: if (!we) begin legal = 1'b1; sz = 1; end
            3'b101: if (!we) begin legal = 1'b1; sz = 2; end
            default: ;
        endcase
    endfunction

    // Memory responder: acks each beat after ack_delay wait cycles
    initial begin
        int          wait_cnt;
        logic        p_req, p_ack;
        logic [68:0] held;
        beat_t       b;
        mem_ack = 1'b0; mem_rdata = '0; wait_cnt = 0; p_req = 1'b0; p_ack = 1'b0; held = '0;
        forever begin
            @(negedge clk);
            if (mem_req && p_req && !p_ack && ({mem_addr, mem_be, mem_we, mem_wdata} !== held))
                stab_viol++;
            if (mem_req) begin
                if (wait_cnt < ack_delay) begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                end else begin
                    mem_ack = 1'b1;
                    wait_cnt = 0;
                    for (int i = 0; i < 4; i++) begin
                        mem_rdata[8*i +: 8] = rd_byte(mem_addr + 32'(i));
                        if (mem_we && mem_be[i]) mem_bytes[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
                    end
                    b.addr = mem_addr; b.be = mem_be; b.we = mem_we; b.wdata = mem_wdata;
                    beats.push_back(b);
                end
            end else begin
                mem_ack = 1'b0;
                wait_cnt = 0;
            end
            p_req = mem_req;
            p_ack = mem_ack;
            held  = {mem_addr, mem_be, mem_we, mem_wdata};
        end
    end

    // One full access on the main instance, checked against the byte-level model
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input string name, output logic [31:0] got);
        bit          legal, sgn, ready_bad, mem_ok;
        int          sz, nb_exp, cyc, exp_lat;
        logic [31:0] exp_rd, base;
        ref_decode(we, f3, legal, sz, sgn);
        base   = addr & 32'hFFFF_FFFC;
        nb_exp = !legal ? 0 : ((int'(addr[1:0]) + sz > 4) ? 2 : 1);
        exp_rd = '0;
        if (legal && !we) begin
            for (int k = 0; k < sz; k++) exp_rd[8*k +: 8] = rd_byte(addr + 32'(k));
            if (sgn && sz < 4 && exp_rd[8*sz-1])
                for (int k = sz; k < 4; k++) exp_rd[8*k +: 8] = 8'hFF;
        end
        got = 'x;
        beats.delete();
        cyc = 0;
        while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!req_ready) begin
            n_tests++; n_fail++;
            $display("FAIL %s ready_timeout: req_ready=%0b required 1", name, req_ready);
            return;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        cyc = 0; ready_bad = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
            end
            if (req_ready) ready_bad = 1'b1;
        end while (!rsp_valid && cyc < 200);
        n_tests++;
        if (!rsp_valid) begin
            n_fail++;
            $display("FAIL %s rsp_timeout: rsp_valid=0 after %0d cycles, required 1", name, cyc);
            return;
        end
        if (rsp_err !== !legal) begin
            n_fail++; $display("FAIL %s rsp_err: got %0b required %0b", name, rsp_err, !legal);
        end
        n_tests++;
        if (rsp_rdata !== exp_rd) begin
            n_fail++; $display("FAIL %s rsp_rdata: got %h required %h", name, rsp_rdata, exp_rd);
        end
        got = rsp_rdata;
        exp_lat = legal ? nb_exp * (ack_delay + 1) + 1 : 1;
        n_tests++;
        if (cyc != exp_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d required %0d", name, cyc, exp_lat);
        end
        n_tests++;
        if (ready_bad) begin
            n_fail++; $display("FAIL %s ready_while_busy: got 1 required 0", name);
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s after_resp: rsp_valid=%0b req_ready=%0b required 0/1", name, rsp_valid, req_ready);
        end
        n_tests++;
        if (beats.size() != nb_exp) begin
            n_fail++; $display("FAIL %s beat_count: got %0d required %0d", name, beats.size(), nb_exp);
        end else begin
            for (int j = 0; j < nb_exp; j++) begin
                logic [31:0] ea, ew, mask, off;
                logic [3:0]  eb;
                ea = base + 32'(4 * j);
                eb = '0; ew = '0; mask = '0;
                for (int i = 0; i < 4; i++) begin
                    off = ea + 32'(i) - addr;
                    if (off < 32'(sz)) begin
                        eb[i] = 1'b1;
                        ew[8*i +: 8] = wd[8*int'(off) +: 8];
                        mask[8*i +: 8] = 8'hFF;
                    end
                end
                n_tests++;
                if (beats[j].addr !== ea || beats[j].be !== eb || beats[j].we !== we) begin
                    n_fail++;
                    $display("FAIL %s beat%0d: got addr=%h be=%b we=%0b required addr=%h be=%b we=%0b",
                             name, j, beats[j].addr, beats[j].be, beats[j].we, ea, eb, we);
                end
                if (we) begin
                    n_tests++;
                    if ((beats[j].wdata & mask) !== ew) begin
                        n_fail++;
                        $display("FAIL %s beat%0d_wdata: got %h required %h (mask %h)", name, j, beats[j].wdata & mask, ew, mask);
                    end
                end
            end
        end
        if (legal && we) begin
            mem_ok = 1'b1;
            for (int k = 0; k < sz; k++) if (rd_byte(addr + 32'(k)) !== wd[8*k +: 8]) mem_ok = 1'b0;
            n_tests++;
            if (!mem_ok) begin
                n_fail++; $display("FAIL %s store_memory: bytes at %h differ from %h", name, addr, wd);
            end
        end
    endtask

    // One load on the no-misalignment instance (memory always acks at once)
    task automatic na_issue(input logic [2:0] f3, input logic [31:0] addr, input bit exp_err,
                            input logic [31:0] exp_rd, input string name);
        int cyc;
        bit saw_req;
        req_we = 1'b0; req_funct3 = f3; req_addr = addr; req_wdata = $urandom;
        na_req_valid = 1'b1;
        @(posedge clk);
        cyc = 0; saw_req = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) na_req_valid = 1'b0;
            if (na_mem_req) saw_req = 1'b1;
        end while (!na_rsp_valid && cyc < 50);
        n_tests++;
        if (!na_rsp_valid || na_rsp_err !== exp_err || na_rsp_rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL %s na_rsp: got valid=%0b err=%0b rdata=%h required 1/%0b/%h",
                     name, na_rsp_valid, na_rsp_err, na_rsp_rdata, exp_err, exp_rd);
        end
        n_tests++;
        if (cyc != (exp_err ? 1 : 2) || saw_req !== !exp_err) begin
            n_fail++;
            $display("FAIL %s na_timing: got latency=%0d mem_req_seen=%0b required %0d/%0b",
                     name, cyc, saw_req, exp_err ? 1 : 2, !exp_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; na_req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b0 || na_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %0b/%0b required 0/0", req_ready, na_req_ready);
        end
        n_tests++;
        if ({rsp_valid, rsp_err, mem_req, mem_we} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {rsp_valid, rsp_err, mem_req, mem_we});
        end
        n_tests++;
        if ({rsp_rdata, mem_addr, mem_be, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_data: got rdata=%h addr=%h be=%b wdata=%h required 0",
                               rsp_rdata, mem_addr, mem_be, mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %0b required 1", req_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] got;
        ack_delay = 0;
        mem_bytes[32'h100] = 8'h00; mem_bytes[32'h101] = 8'h85;
        mem_bytes[32'h102] = 8'h00; mem_bytes[32'h103] = 8'h00;
        do_access(1'b0, 3'b000, 32'h101, 32'h0, "lb_0x101", got);
        n_tests++;
        if (got !== 32'hFFFF_FF85) begin
            n_fail++; $display("FAIL lb_const: got %h required ffffff85", got);
        end
        mem_bytes[32'h103] = 8'h01; mem_bytes[32'h104] = 8'h80;
        do_access(1'b0, 3'b101, 32'h103, 32'h0, "lhu_0x103", got);
        n_tests++;
        if (got !== 32'h0000_8001) begin
            n_fail++; $display("FAIL lhu_const: got %h required 00008001", got);
        end
        do_access(1'b1, 3'b010, 32'h102, 32'h1234_5678, "sw_0x102", got);
        n_tests++;
        if (beats.size() != 2 || beats[0].addr !== 32'h100 || beats[0].be !== 4'b1100 ||
            beats[0].wdata[31:16] !== 16'h5678 || beats[1].addr !== 32'h104 ||
            beats[1].be !== 4'b0011 || beats[1].wdata[15:0] !== 16'h1234) begin
            n_fail++; $display("FAIL sw_const: got %0d beats, required be 1100/5678 and 0011/1234", beats.size());
        end
    endtask

    task automatic test_illegal();
        logic [31:0] got;
        do_access(1'b0, 3'b111, 32'h200, 32'h0, "ld_f3_111", got);
        do_access(1'b0, 3'b011, 32'h200, 32'h0, "ld_f3_011", got);
        do_access(1'b0, 3'b110, 32'h201, 32'h0, "ld_f3_110", got);
        do_access(1'b1, 3'b100, 32'h200, 32'hDEAD_BEEF, "st_f3_100", got);
        do_access(1'b1, 3'b101, 32'h202, 32'hDEAD_BEEF, "st_f3_101", got);
        do_access(1'b1, 3'b011, 32'h203, 32'hDEAD_BEEF, "st_f3_011", got);
    endtask

    task automatic test_no_misalign();
        na_issue(3'b010, 32'h2, 1'b1, 32'h0, "na_lw_0x2");
        na_issue(3'b001, 32'h3, 1'b1, 32'h0, "na_lh_0x3");
        na_issue(3'b010, 32'h4, 1'b0, 32'hCAFE_F00D, "na_lw_0x4");
        na_issue(3'b001, 32'h6, 1'b0, 32'hFFFF_CAFE, "na_lh_0x6");
        na_issue(3'b111, 32'h8, 1'b1, 32'h0, "na_f3_111");
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        ack_delay = 1;
        do_access(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, "lw_wrap", got);
        do_access(1'b1, 3'b001, 32'hFFFF_FFFF, 32'hA5C3_7E19, "sh_wrap", got);
        do_access(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, "lh_wrap", got);
    endtask

    task automatic test_ack_delay();
        logic [31:0] got;
        int          viol0;
        viol0 = stab_viol;
        ack_delay = 3;
        do_access(1'b1, 3'b010, 32'h302, 32'h1234_5678, "dly_sw", got);
        do_access(1'b0, 3'b101, 32'h303, 32'h0, "dly_lhu", got);
        do_access(1'b0, 3'b010, 32'h301, 32'h0, "dly_lw", got);
        do_access(1'b0, 3'b000, 32'h305, 32'h0, "dly_lb", got);
        n_tests++;
        if (stab_viol != viol0) begin
            n_fail++; $display("FAIL mem_hold_stable: got %0d changes while waiting, required 0", stab_viol - viol0);
        end
    endtask

    task automatic test_random();
        logic [31:0] got, addr;
        logic        we;
        for (int t = 0; t < 80; t++) begin
            ack_delay = int'($urandom_range(0, 2));
            we   = 1'($urandom);
            addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                               : (32'h400 + 32'($urandom_range(0, 63)));
            do_access(we, 3'($urandom), addr, $urandom, "random", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        int          cyc;
        bit          rsp_seen;
        ack_delay = 4;
        beats.delete();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h502; req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (beats.size() < 1 && cyc < 50) begin @(negedge clk); cyc++; end
        @(negedge clk);
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h504) begin
            n_fail++; $display("FAIL mid_in_beat1: got mem_req=%0b addr=%h required 1/00000504", mem_req, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_drop: got mem_req=%0b rsp_valid=%0b required 0/0", mem_req, rsp_valid);
        end
        rsp_seen = 1'b0;
        repeat (3) begin @(negedge clk); if (rsp_valid) rsp_seen = 1'b1; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (rsp_valid || mem_req) rsp_seen = 1'b1; end
        n_tests++;
        if (rsp_seen) begin
            n_fail++; $display("FAIL mid_reset_discard: got stray rsp_valid/mem_req=1 required 0");
        end
        ack_delay = 0;
        do_access(1'b0, 3'b010, 32'h0, 32'h0, "post_reset_lw", got);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_no_misalign();
        test_wrap();
        test_ack_delay();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
